// File: rtl/msx_mouse_pkg.sv
// Shared types and helpers for the MSX joystick-port mouse reader.
package msx_mouse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TOGGLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int         NIBBLES      = 4;
   localparam logic [3:0] EMPTY_NIBBLE = 4'hF;

   // Clamp a 10-bit signed sum into the symmetric range [-lim, +lim].
   function automatic logic signed [7:0] saturate(input logic signed [9:0] val,
                                                  input logic signed [9:0] lim);
      logic signed [9:0] neg_lim;
      neg_lim = -lim;
      if (val > lim)
         return lim[7:0];
      else if (val < neg_lim)
         return neg_lim[7:0];
      else
         return val[7:0];
   endfunction

endpackage

// File: rtl/msx_mouse_sync.sv
// Two-flop synchroniser for the six joystick-port pins.
module msx_mouse_sync (
   input  logic       clk_sys,
   input  logic [5:0] d,
   output logic [5:0] q
);

   logic [5:0] sync_p0;

   always_ff @(posedge clk_sys) begin
      sync_p0 <= d;
      q       <= sync_p0;
   end

endmodule

// File: rtl/msx_mouse_reader.sv
// MSX joystick-port mouse reader: strobes four nibbles per poll into X/Y deltas and buttons.
// Build option MSX_MOUSE_ACCUM_EN: saturating delta accumulators cleared by rd_i.
module msx_mouse_reader
   import msx_mouse_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1000,
   parameter int POLL_CYCLES   = 357955,
   parameter int SAT_LIMIT     = 127
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       en_i,
   input  logic [5:0] joy_i,
   output logic       stra_o,
   output logic [7:0] dx_o,
   output logic [7:0] dy_o,
   output logic [1:0] btn_o,
   output logic       valid_o,
   output logic       present_o,
   output logic       busy_o,
   input  logic       rd_i
);

   localparam int              PW          = $clog2(POLL_CYCLES);
   localparam int              SW          = $clog2(SETTLE_CYCLES + 1);
   localparam logic [PW-1:0]   POLL_LAST   = PW'(POLL_CYCLES - 1);
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [1:0]      LAST_NIB    = 2'(NIBBLES - 1);

   logic [5:0]        joy_s;
   state_t            state, state_nxt;
   logic [PW-1:0]     poll_cnt;
   logic [SW-1:0]     settle_cnt;
   logic [1:0]        nib_idx;
   logic [3:0]        nib [NIBBLES];
   logic signed [7:0] raw_x, raw_y;
   logic              present_now;

   msx_mouse_sync u_sync (
      .clk_sys (clk_sys),
      .d       (joy_i),
      .q       (joy_s)
   );

   assign raw_x       = {nib[0], nib[1]};
   assign raw_y       = {nib[2], nib[3]};
   assign present_now = ({nib[0], nib[1], nib[2], nib[3]} != {NIBBLES{EMPTY_NIBBLE}});
   assign busy_o      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (poll_cnt == POLL_LAST && en_i) state_nxt = TOGGLE;
         TOGGLE:  state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == '0) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = (nib_idx == LAST_NIB) ? DONE : TOGGLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         poll_cnt   <= '0;
         settle_cnt <= '0;
         nib_idx    <= '0;
         stra_o     <= 1'b0;
         valid_o    <= 1'b0;
         present_o  <= 1'b0;
         btn_o      <= 2'b00;
      end else begin
         state    <= state_nxt;
         poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
         valid_o  <= 1'b0;
         case (state)
            IDLE:    nib_idx <= '0;
            TOGGLE: begin
               stra_o     <= ~stra_o;
               settle_cnt <= SETTLE_LOAD;
            end
            SETTLE:  if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
            SAMPLE:  nib_idx <= nib_idx + 1'b1;
            DONE: begin
               present_o <= present_now;
               valid_o   <= present_now;
               btn_o     <= present_now ? ~joy_s[5:4] : 2'b00;
            end
            default: ;
         endcase
      end
   end

   // Nibble capture: data path, overwritten by every packet
   always_ff @(posedge clk_sys) begin
      if (state == SAMPLE)
         nib[nib_idx] <= joy_s[3:0];
   end

`ifdef MSX_MOUSE_ACCUM_EN
   localparam logic signed [9:0] SAT_LIM = 10'(SAT_LIMIT);

   logic signed [9:0] acc_x, acc_y, base_x, base_y, sum_x, sum_y;
   logic signed [7:0] sat_x, sat_y;

   // A read ack in the DONE cycle empties the accumulator before the new packet is added.
   assign base_x = rd_i ? '0 : acc_x;
   assign base_y = rd_i ? '0 : acc_y;
   assign sum_x  = base_x + {{2{raw_x[7]}}, raw_x};
   assign sum_y  = base_y + {{2{raw_y[7]}}, raw_y};
   assign sat_x  = saturate(sum_x, SAT_LIM);
   assign sat_y  = saturate(sum_y, SAT_LIM);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         acc_x <= '0;
         acc_y <= '0;
      end else if (state == DONE) begin
         acc_x <= present_now ? {{2{sat_x[7]}}, sat_x} : base_x;
         acc_y <= present_now ? {{2{sat_y[7]}}, sat_y} : base_y;
      end else if (rd_i) begin
         acc_x <= '0;
         acc_y <= '0;
      end
   end

   assign dx_o = present_o ? acc_x[7:0] : 8'h00;
   assign dy_o = present_o ? acc_y[7:0] : 8'h00;
`else
   logic signed [7:0] dx_q, dy_q;
   logic              unused_cfg;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dx_q <= '0;
         dy_q <= '0;
      end else if (state == DONE) begin
         dx_q <= present_now ? raw_x : 8'sd0;
         dy_q <= present_now ? raw_y : 8'sd0;
      end
   end

   assign dx_o       = dx_q;
   assign dy_o       = dy_q;
   assign unused_cfg = rd_i ^ SAT_LIMIT[0];
`endif

endmodule
